// File: rtl/serial_paralelo_alineado_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_paralelo_alineado_if
// Brief    : Serial-in / aligned-word-out bundle for the comma-aligning
//            deserializer. The master drives the serial bit and its enable;
//            the slave returns aligned words plus lock status.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_paralelo_alineado_if #(
  parameter int ANCHO = 10
) ();
  logic             enb;
  logic             entrada;
  logic [ANCHO-1:0] salidas;
  logic             valido;
  logic             es_coma;
  logic             sincronizado;
  logic [1:0]       estado;

  modport master (
    output enb, entrada,
    input  salidas, valido, es_coma, sincronizado, estado
  );

  modport slave (
    input  enb, entrada,
    output salidas, valido, es_coma, sincronizado, estado
  );
endinterface
`default_nettype wire

// File: rtl/serial_paralelo_alineado.sv
`default_nettype none
// ============================================================================
// Module   : serial_paralelo_alineado
// Brief    : Deserializer that hunts for a comma pattern in a 1-bit stream,
//            locks word alignment after repeated aligned commas, emits one
//            aligned word per ANCHO enabled bits, and drops lock after
//            repeated misaligned commas.
// Revision : 1.0 - initial release
// ============================================================================
module serial_paralelo_alineado #(
  parameter int               ANCHO           = 10,
  parameter logic [ANCHO-1:0] COMA            = 10'b0011111010,
  parameter bit               AMBAS_DISP      = 1'b1,
  parameter int               COMAS_SYNC      = 3,
  parameter int               ERRORES_PERDIDA = 2
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  serial_paralelo_alineado_if.slave    bus
);

  localparam int FW = (ANCHO > 1) ? $clog2(ANCHO) : 1;
  localparam int CW = $clog2(COMAS_SYNC + 1);
  localparam int EW = $clog2(ERRORES_PERDIDA + 1);

  localparam logic [FW-1:0] C_FASE_ULT  = FW'(ANCHO - 1);
  localparam logic [CW-1:0] C_COMAS_MAX = CW'(COMAS_SYNC);
  localparam logic [CW-1:0] C_COMAS_UNO = CW'(1);
  localparam logic [EW-1:0] C_ERR_MAX   = EW'(ERRORES_PERDIDA);

  typedef enum logic [1:0] {
    HUNT = 2'b00,
    SYNC = 2'b01,
    LOCK = 2'b10
  } estado_t;

  estado_t          r_estado,    w_estado_n;
  logic [ANCHO-1:0] r_sr,        w_sr_n;
  logic [FW-1:0]    r_fase,      w_fase_n;
  logic [CW-1:0]    r_cnt_comas, w_cnt_comas_n;
  logic [EW-1:0]    r_cnt_err,   w_cnt_err_n;
  logic [ANCHO-1:0] r_salidas,   w_salidas_n;
  logic             r_valido,    w_valido_n;
  logic             r_es_coma,   w_es_coma_n;

  logic [ANCHO-1:0] w_ventana;
  logic             w_hay_coma;
  logic             w_frontera;
  logic [FW-1:0]    w_fase_inc;
  logic [CW-1:0]    w_comas_inc;
  logic [EW-1:0]    w_err_inc;

  // Window includes the bit being sampled now, so a comma is seen on its last bit
  assign w_ventana   = {r_sr[ANCHO-2:0], bus.entrada};
  assign w_hay_coma  = (w_ventana == COMA) || (AMBAS_DISP && (w_ventana == ~COMA));
  assign w_frontera  = (r_fase == C_FASE_ULT);
  assign w_fase_inc  = w_frontera ? '0 : r_fase + 1'b1;
  assign w_comas_inc = (r_cnt_comas == C_COMAS_MAX) ? r_cnt_comas : r_cnt_comas + 1'b1;
  assign w_err_inc   = (r_cnt_err == C_ERR_MAX) ? r_cnt_err : r_cnt_err + 1'b1;

  // Next-state and output decode; everything frozen unless enb is high
  always_comb begin
    w_estado_n    = r_estado;
    w_sr_n        = r_sr;
    w_fase_n      = r_fase;
    w_cnt_comas_n = r_cnt_comas;
    w_cnt_err_n   = r_cnt_err;
    w_salidas_n   = r_salidas;
    w_es_coma_n   = r_es_coma;
    w_valido_n    = 1'b0;

    if (bus.enb) begin
      w_sr_n = w_ventana;
      case (r_estado)
        HUNT: begin
          if (w_hay_coma) begin
            w_fase_n      = '0;
            w_cnt_comas_n = C_COMAS_UNO;
            if (COMAS_SYNC == 1) begin
              // Single-comma lock: this comma is also the first emitted word
              w_estado_n  = LOCK;
              w_cnt_err_n = '0;
              w_salidas_n = w_ventana;
              w_es_coma_n = 1'b1;
              w_valido_n  = 1'b1;
            end else begin
              w_estado_n = SYNC;
            end
          end
        end
        SYNC: begin
          w_fase_n = w_fase_inc;
          if (w_hay_coma) begin
            if (w_frontera) begin
              w_cnt_comas_n = w_comas_inc;
              if (w_comas_inc == C_COMAS_MAX) begin
                w_estado_n  = LOCK;
                w_cnt_err_n = '0;
                w_salidas_n = w_ventana;
                w_es_coma_n = 1'b1;
                w_valido_n  = 1'b1;
              end
            end else begin
              // Comma at a new phase: restart the count from this comma
              w_fase_n      = '0;
              w_cnt_comas_n = C_COMAS_UNO;
            end
          end
        end
        LOCK: begin
          w_fase_n = w_fase_inc;
          if (w_frontera) begin
            w_salidas_n = w_ventana;
            w_es_coma_n = w_hay_coma;
            w_valido_n  = 1'b1;
            if (w_hay_coma) begin
              w_cnt_err_n = '0;
            end
          end else if (w_hay_coma) begin
            w_cnt_err_n = w_err_inc;
            if (w_err_inc == C_ERR_MAX) begin
              // Drop lock; realignment waits for the next comma in HUNT
              w_estado_n    = HUNT;
              w_cnt_comas_n = '0;
            end
          end
        end
        default: begin
          w_estado_n = HUNT;
        end
      endcase
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado    <= HUNT;
      r_sr        <= '0;
      r_fase      <= '0;
      r_cnt_comas <= '0;
      r_cnt_err   <= '0;
      r_salidas   <= '0;
      r_valido    <= 1'b0;
      r_es_coma   <= 1'b0;
    end else begin
      r_estado    <= w_estado_n;
      r_sr        <= w_sr_n;
      r_fase      <= w_fase_n;
      r_cnt_comas <= w_cnt_comas_n;
      r_cnt_err   <= w_cnt_err_n;
      r_salidas   <= w_salidas_n;
      r_valido    <= w_valido_n;
      r_es_coma   <= w_es_coma_n;
    end
  end

  assign bus.salidas      = r_salidas;
  assign bus.valido       = r_valido;
  assign bus.es_coma      = r_es_coma;
  assign bus.sincronizado = (r_estado == LOCK);
  assign bus.estado       = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_serial_paralelo_alineado.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_paralelo_alineado
// Brief    : Self-checking bench for the comma-aligning deserializer. Words
//            expected from the DUT are queued as stimulus is driven and
//            compared (value, comma flag, enabled-bit index) on each valido.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_paralelo_alineado;

  localparam int N = 10;
  localparam logic [N-1:0] C_COMA   = 10'b0011111010;
  localparam logic [N-1:0] C_COMA_P = 10'b1100000101;
  localparam logic [N-1:0] C_DATA   = 10'b1010101010;
  localparam logic [N-1:0] C_D1     = 10'b1100110011;
  localparam logic [N-1:0] C_D2     = 10'b0101001101;
  localparam logic [N-1:0] C_D3     = 10'b0110100110;
  localparam logic [N-1:0] C_SLIP   = 10'b0001111101;

  typedef struct packed {
    logic [N-1:0] w;
    logic         c;
    logic [31:0]  n;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enb = 1'b0;
  logic entrada = 1'b0;
  logic enb_last = 1'b0;
  int   n_en = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  serial_paralelo_alineado_if #(.ANCHO(N)) bus_a ();
  serial_paralelo_alineado_if #(.ANCHO(N)) bus_b ();

  assign bus_a.enb     = enb;
  assign bus_a.entrada = entrada;
  assign bus_b.enb     = enb;
  assign bus_b.entrada = entrada;

  serial_paralelo_alineado #(.ANCHO(N)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  serial_paralelo_alineado #(.ANCHO(N), .AMBAS_DISP(1'b0)) u_dut_rdm (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One bit per clock; inputs change just after the sampling edge
  task automatic drive(input logic b, input logic en);
    enb     = en;
    entrada = b;
    @(posedge clk);
    enb_last = en;
    if (en && !rst) n_en++;
    #1;
  endtask

  task automatic send_word(input logic [N-1:0] w);
    for (int i = N - 1; i >= 0; i--) drive(w[i], 1'b1);
  endtask

  task automatic send_word_gated(input logic [N-1:0] w);
    for (int i = N - 1; i >= 0; i--) begin
      drive(w[i], 1'b1);
      drive(1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  // Expect a word whose last bit is the off-th enabled bit from now
  task automatic expect_at(input logic [N-1:0] w, input logic c, input int off);
    exp_t e;
    e.w = w;
    e.c = c;
    e.n = 32'(n_en + off);
    q.push_back(e);
  endtask

  task automatic expect_word(input logic [N-1:0] w, input logic c);
    expect_at(w, c, N);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    rst = 1'b0;
  endtask

  // Scoreboard side: every valido must match the oldest expected word
  always @(negedge clk) begin
    if (bus_a.valido) begin
      check("valido_enb", 32'(enb_last), 32'd1);
      if (q.size() == 0) begin
        check("valido_unexp", 32'(bus_a.valido), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("salidas", 32'(bus_a.salidas), 32'(e.w));
        check("es_coma", 32'(bus_a.es_coma), 32'(e.c));
        check("bit_idx", 32'(n_en), e.n);
      end
    end
  end

  initial begin
    // Reset, then a partial word, then a mid-stream reset with enb high
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    rst = 1'b0;
    foreach (C_DATA[i]) if (i < 7) drive(C_DATA[i], 1'b1);
    do_reset();
    check("rst_salidas", 32'(bus_a.salidas), 32'd0);
    check("rst_valido", 32'(bus_a.valido), 32'd0);
    check("rst_es_coma", 32'(bus_a.es_coma), 32'd0);
    check("rst_sinc", 32'(bus_a.sincronizado), 32'd0);
    check("rst_estado", 32'(bus_a.estado), 32'd0);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1);
    check("idle_estado", 32'(bus_a.estado), 32'd0);

    // Acquisition at an arbitrary phase
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    send_word(C_COMA);
    check("acq_estado1", 32'(bus_a.estado), 32'd1);
    send_word(C_COMA);
    check("acq_estado2", 32'(bus_a.estado), 32'd1);
    check("acq_sinc2", 32'(bus_a.sincronizado), 32'd0);
    expect_word(C_COMA, 1'b1);
    send_word(C_COMA);
    check("acq_estado3", 32'(bus_a.estado), 32'd2);
    check("acq_sinc3", 32'(bus_a.sincronizado), 32'd1);
    expect_word(C_DATA, 1'b0);
    send_word(C_DATA);

    // Same words continuous, then with enb toggling
    expect_word(C_D1, 1'b0); send_word(C_D1);
    expect_word(C_D2, 1'b0); send_word(C_D2);
    expect_word(C_D3, 1'b0); send_word(C_D3);
    expect_word(C_D1, 1'b0); send_word_gated(C_D1);
    expect_word(C_D2, 1'b0); send_word_gated(C_D2);
    expect_word(C_D3, 1'b0); send_word_gated(C_D3);
    check("gate_sinc", 32'(bus_a.sincronizado), 32'd1);

    // RD+ comma: locks only where both disparities count
    do_reset();
    check("rdp_estado0", 32'(bus_a.estado), 32'd0);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    send_word(C_COMA_P);
    check("rdp_estado1", 32'(bus_a.estado), 32'd1);
    send_word(C_COMA_P);
    expect_word(C_COMA_P, 1'b1);
    send_word(C_COMA_P);
    check("rdp_estado3", 32'(bus_a.estado), 32'd2);
    check("rdm_estado3", 32'(bus_b.estado), 32'd0);
    expect_word(C_DATA, 1'b0);
    send_word(C_DATA);
    check("rdm_estado4", 32'(bus_b.estado), 32'd0);

    // Slip of one bit while locked: second misaligned comma drops lock
    drive(1'b0, 1'b1);
    expect_at(C_SLIP, 1'b0, 9);
    send_word(C_COMA);
    check("slip_sinc1", 32'(bus_a.sincronizado), 32'd1);
    check("slip_estado1", 32'(bus_a.estado), 32'd2);
    expect_at(C_SLIP, 1'b0, 9);
    send_word(C_COMA);
    check("slip_sinc2", 32'(bus_a.sincronizado), 32'd0);
    check("slip_estado2", 32'(bus_a.estado), 32'd0);
    send_word(C_COMA);
    check("relock_estado1", 32'(bus_a.estado), 32'd1);
    send_word(C_COMA);
    check("relock_estado2", 32'(bus_a.estado), 32'd1);
    expect_word(C_COMA, 1'b1);
    send_word(C_COMA);
    check("relock_estado3", 32'(bus_a.estado), 32'd2);

    // Realignment inside SYNC restarts the comma count
    do_reset();
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    send_word(C_COMA);
    send_word(C_COMA);
    check("real_estado2", 32'(bus_a.estado), 32'd1);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    send_word(C_COMA);
    check("real_estado3", 32'(bus_a.estado), 32'd1);
    send_word(C_COMA);
    check("real_estado4", 32'(bus_a.estado), 32'd1);
    expect_word(C_COMA, 1'b1);
    send_word(C_COMA);
    check("real_estado5", 32'(bus_a.estado), 32'd2);

    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0);
    check("sb_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
